// File: rtl/loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
// Holds the loader and receiver state encodings, the frame magic byte,
// the byte offsets of the frame fields and the running-checksum helper.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_MAGIC = 3'd0,
        ST_LEN_LO     = 3'd1,
        ST_LEN_HI     = 3'd2,
        ST_DATA       = 3'd3,
        ST_CSUM       = 3'd4,
        ST_DONE       = 3'd5,
        ST_ERROR      = 3'd6
    } loader_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    localparam logic [7:0] LOADER_MAGIC = 8'hA5;

    // Byte offsets of the frame fields; the checksum follows the 4*N data bytes.
    localparam int OFS_MAGIC    = 0;
    localparam int OFS_COUNT_LO = 1;
    localparam int OFS_COUNT_HI = 2;
    localparam int OFS_DATA     = 3;

    // The frame checksum is a plain XOR over count and data bytes.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first.
// Ports: clk, rst_n (sync, active-low), rx_i (async serial, idle high),
//        byte_o (received byte), byte_valid_o (1-cycle strobe),
//        frame_err_o (1-cycle strobe when the stop bit reads 0; no byte emitted).
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1_q, sync2_q;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    // Bit-timing next-state logic: confirm start at half-bit, then sample each bit one full bit later.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    if (!sync2_q) begin
                        state_d = RX_DATA;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_BREAK: begin
                // A low stop bit may run on; wait for the line to idle so it is not taken as a new start.
                if (sync2_q) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_BREAK;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // Receiver state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a framed program image over UART, writes 32-bit
// little-endian words into instruction memory and releases the core reset
// only after the whole image has arrived with a matching XOR checksum.
// Ports: clk, rst_n (sync, active-low), uart_rx_i (serial in),
//        imem_we/imem_addr/imem_wdata (memory write port, one strobe per word),
//        core_rst_n (core reset, high only when the image is accepted),
//        load_done, load_error, busy (loader status).
module imem_uart_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int ADDR_W       = $clog2(DEPTH_WORDS),
    parameter int CLKS_PER_BIT = 234,
    parameter int TIMEOUT_CLKS = 2700000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx_i,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_error,
    output logic              busy
);

    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    logic [7:0] rx_byte_s;
    logic       rx_valid_s;
    logic       rx_ferr_s;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (uart_rx_i),
        .byte_o       (rx_byte_s),
        .byte_valid_o (rx_valid_s),
        .frame_err_o  (rx_ferr_s)
    );

    loader_state_t     state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        csum_q, csum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              in_frame_s;
    logic              abort_s;
    logic [15:0]       count_s;

    // Frame-parsing next-state logic, write-port generation and status decode.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        csum_d  = csum_q;
        tmo_d   = '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_s = {rx_byte_s, len_q[7:0]};

        in_frame_s = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                     (state_q == ST_DATA)   || (state_q == ST_CSUM);

        // Inter-byte idle counter; a byte arriving in the expiry cycle still wins.
        if (in_frame_s && !rx_valid_s) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = '0;
        end

        abort_s = in_frame_s && (rx_ferr_s || (!rx_valid_s && (tmo_q == TMO_LAST)));

        if (abort_s) begin
            state_d = ST_ERROR;
        end else begin
            case (state_q)
                ST_WAIT_MAGIC, ST_DONE, ST_ERROR: begin
                    if (rx_valid_s && (rx_byte_s == LOADER_MAGIC)) begin
                        state_d = ST_LEN_LO;
                        csum_d  = 8'h00;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_LEN_LO: begin
                    if (rx_valid_s) begin
                        len_d   = {8'h00, rx_byte_s};
                        csum_d  = csum_update(csum_q, rx_byte_s);
                        state_d = ST_LEN_HI;
                    end else begin
                        state_d = ST_LEN_LO;
                    end
                end
                ST_LEN_HI: begin
                    if (rx_valid_s) begin
                        len_d  = count_s;
                        csum_d = csum_update(csum_q, rx_byte_s);
                        wcnt_d = 16'd0;
                        lane_d = 2'd0;
                        if (count_s > 16'(DEPTH_WORDS)) begin
                            state_d = ST_ERROR;
                        end else if (count_s == 16'd0) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_LEN_HI;
                    end
                end
                ST_DATA: begin
                    if (rx_valid_s) begin
                        csum_d = csum_update(csum_q, rx_byte_s);
                        case (lane_q)
                            2'd0: begin
                                asm_d[7:0] = rx_byte_s;
                                lane_d     = 2'd1;
                            end
                            2'd1: begin
                                asm_d[15:8] = rx_byte_s;
                                lane_d      = 2'd2;
                            end
                            2'd2: begin
                                asm_d[23:16] = rx_byte_s;
                                lane_d       = 2'd3;
                            end
                            default: begin
                                // Fourth byte completes the word; the write strobe appears next cycle.
                                we_d    = 1'b1;
                                addr_d  = wcnt_q[ADDR_W-1:0];
                                wdata_d = {rx_byte_s, asm_q};
                                wcnt_d  = wcnt_q + 16'd1;
                                lane_d  = 2'd0;
                                if ((wcnt_q + 16'd1) == len_q) begin
                                    state_d = ST_CSUM;
                                end else begin
                                    state_d = ST_DATA;
                                end
                            end
                        endcase
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (rx_valid_s) begin
                        if (rx_byte_s == csum_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end else begin
                        state_d = ST_CSUM;
                    end
                end
                default: begin
                    state_d = ST_WAIT_MAGIC;
                end
            endcase
        end

        // Status outputs are decoded from the next state so they register with the transition.
        core_rst_n_d = (state_d == ST_DONE);
        done_d       = (state_d == ST_DONE);
        err_d        = (state_d == ST_ERROR);
        busy_d       = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                       (state_d == ST_DATA)   || (state_d == ST_CSUM);
    end

    // Loader state, write-port and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT_MAGIC;
            len_q        <= 16'd0;
            wcnt_q       <= 16'd0;
            lane_q       <= 2'd0;
            asm_q        <= 24'd0;
            csum_q       <= 8'h00;
            tmo_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            wcnt_q       <= wcnt_d;
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            csum_q       <= csum_d;
            tmo_q        <= tmo_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_rst_n_q <= core_rst_n_d;
            done_q       <= done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign load_done  = done_q;
    assign load_error = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: drives UART frames, predicts the
// memory writes and final status from a frame-level model, and checks every
// write strobe as it happens.
module tb_imem_uart_loader;

    localparam int CPB    = 4;
    localparam int TMO    = 200;
    localparam int DEPTH  = 1024;
    localparam int AW     = 10;

    logic          clk;
    logic          rst_n;
    logic          uart_rx_i;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst_n;
    logic          load_done;
    logic          load_error;
    logic          busy;

    imem_uart_loader #(
        .DEPTH_WORDS  (DEPTH),
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx_i  (uart_rx_i),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .load_done  (load_done),
        .load_error (load_error),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: expected writes and expected final status.
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done = 1'b0;
    bit          exp_err  = 1'b0;
    logic [7:0]  model_csum = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level prediction: first 0xA5 starts the frame; a short frame ends in ERROR (timeout).
    function automatic void model_frame(input logic [7:0] fb[$]);
        int k;
        int n;
        int base;
        logic [7:0]  cs;
        logic [31:0] w;
        k = -1;
        for (int i = 0; i < fb.size(); i++) begin
            if (k < 0 && fb[i] == 8'hA5) k = i;
        end
        if (k < 0) return;
        exp_done = 1'b0;
        exp_err  = 1'b1;
        if (fb.size() < k + 3) return;
        n  = int'({fb[k+2], fb[k+1]});
        cs = fb[k+1] ^ fb[k+2];
        if (n > DEPTH) return;
        for (int wi = 0; wi < n; wi++) begin
            base = k + 3 + 4 * wi;
            if (fb.size() < base + 4) return;
            w = {fb[base+3], fb[base+2], fb[base+1], fb[base]};
            cs = cs ^ fb[base] ^ fb[base+1] ^ fb[base+2] ^ fb[base+3];
            exp_addr.push_back(wi);
            exp_data.push_back(w);
        end
        model_csum = cs;
        if (fb.size() < k + 3 + 4 * n + 1) return;
        if (fb[k + 3 + 4 * n] == cs) begin
            exp_done = 1'b1;
            exp_err  = 1'b0;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        uart_rx_i = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_rx_i = stop_v;
        repeat (CPB) @(posedge clk);
        uart_rx_i = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] fb[$]);
        for (int i = 0; i < fb.size(); i++) send_byte(fb[i], 1'b1);
    endtask

    task automatic check_status(input string tag);
        @(negedge clk);
        chk({tag, "_load_done"},  {31'd0, load_done},  {31'd0, exp_done});
        chk({tag, "_load_error"}, {31'd0, load_error}, {31'd0, exp_err});
        chk({tag, "_core_rst_n"}, {31'd0, core_rst_n}, {31'd0, exp_done});
        chk({tag, "_busy"},       {31'd0, busy},       32'd0);
        chk({tag, "_writes_left"}, exp_addr.size(),    32'd0);
    endtask

    // Every write strobe must match the next predicted (address, word) pair.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (exp_addr.size() == 0) begin
                chk("unexpected_we", {22'd0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                chk("we_addr", {22'd0, imem_addr}, exp_addr.pop_front());
                chk("we_data", imem_wdata, exp_data.pop_front());
            end
        end
    end

    logic [7:0] f_good[$] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                              8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
    logic [7:0] f_bad[$]  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                              8'h6F, 8'h00, 8'h00, 8'h00, 8'h7F};
    logic [7:0] f_empty[$] = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    logic [7:0] f_big[$]   = '{8'hA5, 8'h01, 8'h04};
    logic [7:0] f_short[$] = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
    logic [7:0] f_part[$]  = '{8'hA5, 8'h01, 8'h00, 8'h13};
    logic [7:0] f_magic[$] = '{8'hA5};
    logic [7:0] f_mid[$]   = '{8'h01, 8'h00, 8'h13};
    logic [7:0] f_junk[$]  = '{8'h00};

    initial begin
        bit seen;
        rst_n     = 1'b0;
        uart_rx_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_we",    {31'd0, imem_we},    32'd0);
        chk("rst_imem_addr",  {22'd0, imem_addr},  32'd0);
        chk("rst_imem_wdata", imem_wdata,          32'd0);
        chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        chk("rst_load_done",  {31'd0, load_done},  32'd0);
        chk("rst_load_error", {31'd0, load_error}, 32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Good two-word frame; pin the model against hand-computed values first.
        model_frame(f_good);
        chk("model_nwords", exp_data.size(), 32'd2);
        chk("model_word0",  exp_data[0], 32'h0000_0013);
        chk("model_word1",  exp_data[1], 32'h0000_006F);
        chk("model_csum",   {24'd0, model_csum}, 32'h0000_007E);
        chk("model_done",   {31'd0, exp_done}, 32'd1);
        send_bytes(f_good);
        repeat (10) @(posedge clk);
        check_status("good");

        // Checksum mismatch: both words still written, image rejected.
        model_frame(f_bad);
        chk("model_bad_err", {31'd0, exp_err}, 32'd1);
        send_bytes(f_bad);
        repeat (10) @(posedge clk);
        check_status("badcsum");

        // Leading garbage then an empty image.
        model_frame(f_empty);
        send_bytes(f_empty);
        repeat (10) @(posedge clk);
        check_status("empty");

        // N = 1025 exceeds the memory depth.
        model_frame(f_big);
        send_bytes(f_big);
        repeat (10) @(posedge clk);
        check_status("toobig");
        model_frame(f_good);
        send_bytes(f_good);
        repeat (10) @(posedge clk);
        check_status("recover");

        // Line goes idle mid-word past the timeout.
        model_frame(f_short);
        send_bytes(f_short);
        repeat (250) @(posedge clk);
        check_status("timeout");

        // Stop bit of 0 in the data phase; checked well before any timeout.
        model_frame(f_part);
        send_bytes(f_part);
        send_byte(8'h00, 1'b0);
        repeat (2) @(posedge clk);
        check_status("stopbit");

        // Reach DONE, then re-flash with a new magic byte.
        model_frame(f_good);
        send_bytes(f_good);
        repeat (10) @(posedge clk);
        check_status("preflash");
        send_byte(8'hA5, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        chk("reflash_busy",       {31'd0, seen},       32'd1);
        chk("reflash_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        chk("reflash_load_done",  {31'd0, load_done},  32'd0);

        // Reset in the middle of the data phase.
        send_bytes(f_mid);
        @(posedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mrst_imem_we",    {31'd0, imem_we},    32'd0);
        chk("mrst_imem_addr",  {22'd0, imem_addr},  32'd0);
        chk("mrst_imem_wdata", imem_wdata,          32'd0);
        chk("mrst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        chk("mrst_load_done",  {31'd0, load_done},  32'd0);
        chk("mrst_load_error", {31'd0, load_error}, 32'd0);
        chk("mrst_busy",       {31'd0, busy},       32'd0);
        rst_n    = 1'b1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        repeat (4) @(posedge clk);
        // A non-magic byte is ignored only if the loader is back waiting for magic.
        model_frame(f_junk);
        send_bytes(f_junk);
        repeat (10) @(posedge clk);
        check_status("postrst");
        model_frame(f_good);
        send_bytes(f_good);
        repeat (10) @(posedge clk);
        check_status("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
